svm_score_accum: RTL and testbench

SVM_SCORE_ACCUM -- requirements
Module: svm_score_accum

---
 rtl/svm_score_accum.sv | 156 +++++++++++++++
 tb/tb_svm_score_accum.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/svm_score_accum.sv
// SVM window score accumulator: sums WINCOLS slice partial sums per window, adds BIAS,
// and queues {score, window, row, detect} in a FIFO. Define SVMSCORE_SAT_EN for saturating adds.
module svm_score_accum #(
   parameter int unsigned WINCOLS = 8,
   parameter int unsigned WPI     = 40,
   parameter int          BIAS    = 0,
   parameter int unsigned FDEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [31:0]             svm_data,
   input  logic                    dvi,
   input  logic                    frame_clr,
   input  logic [31:0]             threshold,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_score,
   output logic [$clog2(WPI)-1:0]  out_win,
   output logic [15:0]             out_row,
   output logic                    out_detect,
   output logic                    overflow,
   output logic                    busy
);

   localparam int unsigned WCW = (WINCOLS > 1) ? $clog2(WINCOLS) : 1;
   localparam int unsigned WW  = $clog2(WPI);
   localparam int unsigned PW  = $clog2(FDEPTH);

   typedef struct packed {
      logic [31:0]   score;
      logic [WW-1:0] win;
      logic [15:0]   row;
      logic          detect;
   } entry_t;

   function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] s;
      s = a + b;
`ifdef SVMSCORE_SAT_EN
      if ((a[31] == b[31]) && (s[31] != a[31])) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return s;
   endfunction

   logic [WCW-1:0] wordcnt_q, wordcnt_d;
   logic [WW-1:0]  wincnt_q, wincnt_d;
   logic [15:0]    rowcnt_q, rowcnt_d;
   logic [31:0]    acc_q, acc_d, thr_q, thr_d;
   logic           ovf_q, ovf_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]    cnt_q, cnt_d;
   entry_t         head_q, head_d;
   logic           head_vld_q, head_vld_d;
   entry_t         mem [FDEPTH];

   logic           first, last, wr, full, pop, wr_ok;
   logic [31:0]    sum, score, thr_use;
   entry_t         wr_entry;

   assign first   = (wordcnt_q == '0);
   assign last    = (wordcnt_q == WCW'(WINCOLS - 1));
   // Word 0 starts from zero so a one-word window still works.
   assign sum     = add32(first ? 32'd0 : acc_q, svm_data);
   assign score   = add32(sum, 32'(BIAS));
   assign thr_use = first ? threshold : thr_q;
   assign wr      = dvi && !frame_clr && last;
   assign full    = (cnt_q == (PW+1)'(FDEPTH));
   assign pop     = head_vld_q && out_ready;
   assign wr_ok   = wr && (!full || pop);

   assign wr_entry = '{score: score, win: wincnt_q, row: rowcnt_q,
                       detect: ($signed(score) > $signed(thr_use))};

   always_comb begin
      wordcnt_d = wordcnt_q;
      wincnt_d  = wincnt_q;
      rowcnt_d  = rowcnt_q;
      acc_d     = acc_q;
      thr_d     = thr_q;
      if (frame_clr) begin
         wordcnt_d = '0;
         wincnt_d  = '0;
         rowcnt_d  = '0;
         acc_d     = '0;
      end else if (dvi) begin
         acc_d = sum;
         if (first) thr_d = threshold;
         if (last) begin
            wordcnt_d = '0;
            if (wincnt_q == WW'(WPI - 1)) begin
               wincnt_d = '0;
               rowcnt_d = rowcnt_q + 16'd1;
            end else begin
               wincnt_d = wincnt_q + WW'(1);
            end
         end else begin
            wordcnt_d = wordcnt_q + WCW'(1);
         end
      end
   end

   always_comb begin
      ovf_d      = frame_clr ? 1'b0 : (ovf_q || (wr && full && !pop));
      wr_ptr_d   = wr_ptr_q + PW'(wr_ok);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      cnt_d      = cnt_q + (PW+1)'(wr_ok) - (PW+1)'(pop);
      head_vld_d = head_vld_q;
      head_d     = head_q;
      // The head is a copy of the oldest stored entry; it stays counted until popped.
      if (!head_vld_q || pop) begin
         head_vld_d = ((cnt_q - (PW+1)'(pop)) != '0);
         if (head_vld_d) head_d = mem[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_q] <= wr_entry;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wordcnt_q  <= '0;
         wincnt_q   <= '0;
         rowcnt_q   <= '0;
         acc_q      <= '0;
         thr_q      <= '0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         head_q     <= '0;
         head_vld_q <= 1'b0;
      end else begin
         wordcnt_q  <= wordcnt_d;
         wincnt_q   <= wincnt_d;
         rowcnt_q   <= rowcnt_d;
         acc_q      <= acc_d;
         thr_q      <= thr_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         head_q     <= head_d;
         head_vld_q <= head_vld_d;
      end
   end

   assign out_valid  = head_vld_q;
   assign out_score  = head_q.score;
   assign out_win    = head_q.win;
   assign out_row    = head_q.row;
   assign out_detect = head_q.detect;
   assign overflow   = ovf_q;
   assign busy       = (wordcnt_q != '0);

endmodule

// File: tb/tb_svm_score_accum.sv
// Directed bench for svm_score_accum at default parameters: basic window, threshold sampling,
// row wrap, backpressure/overflow, 32-bit add behaviour, frame clear and reset mid-window.
module tb_svm_score_accum;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] svm_data = '0;
   logic        dvi = 1'b0;
   logic        frame_clr = 1'b0;
   logic [31:0] threshold = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_score;
   logic [5:0]  out_win;
   logic [15:0] out_row;
   logic        out_detect;
   logic        overflow;
   logic        busy;

   int passes = 0;
   int total  = 0;

   svm_score_accum dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .svm_data   (svm_data),
      .dvi        (dvi),
      .frame_clr  (frame_clr),
      .threshold  (threshold),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_score  (out_score),
      .out_win    (out_win),
      .out_row    (out_row),
      .out_detect (out_detect),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called at a negedge; the word is sampled at the next posedge, returns at the next negedge.
   task automatic send(input logic [31:0] v);
      dvi = 1'b1;
      svm_data = v;
      @(negedge clk);
      dvi = 1'b0;
   endtask

   task automatic clr();
      frame_clr = 1'b1;
      @(negedge clk);
      frame_clr = 1'b0;
   endtask

   logic [31:0] sat_exp;
   logic        sat_det;

   initial begin
`ifdef SVMSCORE_SAT_EN
      sat_exp = 32'h7FFF_FFFF;
      sat_det = 1'b1;
`else
      sat_exp = 32'hFFFF_FF80;
      sat_det = 1'b0;
`endif
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_score", out_score, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic window 1..8 with a dvi gap, threshold 30
      threshold = 32'd30;
      for (int i = 1; i <= 4; i++) send(32'(i));
      @(negedge clk);
      chk("gap_busy", 32'(busy), 32'd1);
      for (int i = 5; i <= 8; i++) send(32'(i));
      chk("basic_valid_early", 32'(out_valid), 32'd0);
      chk("basic_busy_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_score", out_score, 32'd36);
      chk("basic_win", 32'(out_win), 32'd0);
      chk("basic_row", 32'(out_row), 32'd0);
      chk("basic_detect", 32'(out_detect), 32'd1);
      @(negedge clk);
      chk("basic_popped", 32'(out_valid), 32'd0);

      // Threshold sampled on word 0: 31 > 30 even though threshold rises mid-window
      send(32'd31);
      threshold = 32'd100;
      for (int i = 1; i < 8; i++) send(32'd0);
      @(negedge clk);
      chk("thr_score", out_score, 32'd31);
      chk("thr_win", 32'(out_win), 32'd1);
      chk("thr_detect", 32'(out_detect), 32'd1);
      // Score equal to threshold is not a detection
      threshold = 32'd30;
      send(32'd30);
      for (int i = 1; i < 8; i++) send(32'd0);
      @(negedge clk);
      chk("eq_detect", 32'(out_detect), 32'd0);
      chk("eq_win", 32'(out_win), 32'd2);

      // Row wrap: 40 zero windows, then a 41st with score -5
      threshold = 32'd0;
      clr();
      for (int w = 0; w < 40; w++)
         for (int i = 0; i < 8; i++) send(32'd0);
      repeat (3) @(negedge clk);
      chk("row_drained", 32'(out_valid), 32'd0);
      send(32'hFFFF_FFFB);
      for (int i = 1; i < 8; i++) send(32'd0);
      @(negedge clk);
      chk("row_valid", 32'(out_valid), 32'd1);
      chk("row_win", 32'(out_win), 32'd0);
      chk("row_row", 32'(out_row), 32'd1);
      chk("row_score", out_score, 32'hFFFF_FFFB);
      chk("row_detect", 32'(out_detect), 32'd0);
      @(negedge clk);

      // Backpressure: 5 windows with scores 1..5, FIFO of 4
      clr();
      out_ready = 1'b0;
      for (int w = 0; w < 5; w++) begin
         send(32'(w + 1));
         for (int i = 1; i < 8; i++) send(32'd0);
      end
      repeat (3) @(negedge clk);
      chk("bp_ovf", 32'(overflow), 32'd1);
      chk("bp_hold_score", out_score, 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_score", out_score, 32'(k + 1));
         chk("bp_win", 32'(out_win), 32'(k));
         out_ready = 1'b1;
         @(negedge clk);
      end
      chk("bp_empty", 32'(out_valid), 32'd0);
      chk("bp_ovf_sticky", 32'(overflow), 32'd1);
      clr();
      chk("bp_ovf_clr", 32'(overflow), 32'd0);

      // Eight words of 0x7FFFFFF0
      for (int i = 0; i < 8; i++) send(32'h7FFF_FFF0);
      @(negedge clk);
      chk("sat_score", out_score, sat_exp);
      chk("sat_detect", 32'(out_detect), 32'(sat_det));
      @(negedge clk);

      // Clear mid-window with coincident dvi
      clr();
      for (int i = 0; i < 3; i++) send(32'd50);
      frame_clr = 1'b1;
      send(32'd99);
      frame_clr = 1'b0;
      chk("clr_busy", 32'(busy), 32'd0);
      for (int i = 1; i <= 8; i++) send(32'(i));
      chk("clr_busy_end", 32'(busy), 32'd0);
      @(negedge clk);
      chk("clr_score", out_score, 32'd36);
      chk("clr_win", 32'(out_win), 32'd0);
      @(negedge clk);
      chk("clr_single", 32'(out_valid), 32'd0);

      // Reset mid-window discards the partial window
      for (int i = 0; i < 3; i++) send(32'd7);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mrst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      for (int i = 1; i <= 8; i++) send(32'(i));
      @(negedge clk);
      chk("mrst_valid", 32'(out_valid), 32'd1);
      chk("mrst_score", out_score, 32'd36);
      chk("mrst_win", 32'(out_win), 32'd0);
      chk("mrst_row", 32'(out_row), 32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
